// File: rtl/uart_score_pkg.sv
// uart_score_pkg: ASCII constants, report layout and serialiser states (UART_TX_PARITY_EN adds the parity state)
package uart_score_pkg;
    localparam int MSG_LEN = 9;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_B     = 8'h42;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_QMARK = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PAR,
`endif
        ST_STOP
    } tx_state_e;

    function automatic logic [7:0] digit(input logic [3:0] v);
        return (v <= 4'd9) ? ASC_0 + 8'(v) : ASC_QMARK;
    endfunction

    // "A:<a> B:<b>\r\n"
    function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [3:0] a, input logic [3:0] b);
        case (idx)
            4'd0:    return ASC_A;
            4'd1:    return ASC_COLON;
            4'd2:    return digit(a);
            4'd3:    return ASC_SP;
            4'd4:    return ASC_B;
            4'd5:    return ASC_COLON;
            4'd6:    return digit(b);
            4'd7:    return ASC_CR;
            default: return ASC_LF;
        endcase
    endfunction
endpackage

// File: rtl/uart_score_tx_byte.sv
// uart_tx_byte: one UART frame per start, back-to-back capable; UART_TX_PARITY_EN inserts even parity before stop
module uart_tx_byte
    import uart_score_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          tick, load;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        tick    = cnt_q == '0;
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_START : ST_IDLE;
            ST_START: state_d = tick ? ST_DATA : ST_START;
`ifdef UART_TX_PARITY_EN
            ST_DATA:  state_d = (tick && bit_q == 3'd7) ? ST_PAR : ST_DATA;
            ST_PAR:   state_d = tick ? ST_STOP : ST_PAR;
`else
            ST_DATA:  state_d = (tick && bit_q == 3'd7) ? ST_STOP : ST_DATA;
`endif
            ST_STOP:  state_d = tick ? (start ? ST_START : ST_IDLE) : ST_STOP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A new byte may be loaded in the last stop-bit cycle, so frames chain without an idle gap
    always_comb begin
        ready = state_q == ST_IDLE || (state_q == ST_STOP && tick);
        load  = ready && start;
        cnt_d = (state_q == ST_IDLE || tick) ? CW'(CLKS_PER_BIT - 1) : cnt_q - 1'b1;
        bit_d = (state_q == ST_DATA && tick) ? bit_q + 3'd1 : bit_q;
        sh_d  = load ? data : ((state_q == ST_DATA && tick) ? sh_q >> 1 : sh_q);
`ifdef UART_TX_PARITY_EN
        par_d = load ? ^data : par_q;
        tx_d  = state_d == ST_START ? 1'b0 : state_d == ST_DATA ? sh_d[0] : state_d == ST_PAR ? par_q : 1'b1;
`else
        tx_d  = state_d == ST_START ? 1'b0 : state_d == ST_DATA ? sh_d[0] : 1'b1;
`endif
    end

    assign tx = tx_q;
endmodule

// File: rtl/uart_score_tx.sv
// uart_score_tx: sends "A:<a> B:<b>\r\n" as UART frames on send; UART_TX_PARITY_EN selects 8E1 framing
module uart_score_tx
    import uart_score_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [3:0] score_a,
    input  logic [3:0] score_b,
    output logic       busy,
    output logic       done,
    output logic       RsTx
);
    logic [3:0] idx_q, idx_d;
    logic [3:0] sa_q, sa_d, sb_q, sb_d;
    logic [3:0] pa_q, pa_d, pb_q, pb_d;
    logic       busy_q, busy_d, pend_q, pend_d, done_q, done_d;
    logic       ready, start, last;
    logic [7:0] data;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            pa_q   <= '0;
            pb_q   <= '0;
            busy_q <= 1'b0;
            pend_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            pa_q   <= pa_d;
            pb_q   <= pb_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
            done_q <= done_d;
        end
    end

    // A send arriving in the final stop-bit cycle counts as pending, so it chains like any other
    always_comb begin
        last   = busy_q && ready && idx_q == 4'(MSG_LEN - 1);
        start  = busy_q ? ready && (!last || pend_q || send) : send;
        busy_d = busy_q ? !last || pend_q || send : send;
        idx_d  = (!busy_q || last) ? 4'd0 : idx_q + 4'(ready);
        pa_d   = send ? score_a : pa_q;
        pb_d   = send ? score_b : pb_q;
        pend_d = busy_q && !last && (pend_q || send);
        sa_d   = !busy_q ? score_a : (last ? pa_d : sa_q);
        sb_d   = !busy_q ? score_b : (last ? pb_d : sb_q);
        data   = msg_byte(idx_d, sa_q, sb_q);
        done_d = last;
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .tx    (RsTx),
        .ready (ready)
    );

    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_uart_score_tx.sv
// tb_uart_score_tx: random score reports decoded off RsTx and checked against a string-built expected report
module tb_uart_score_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int REPORT = 9 * FRAME * CPB;

    logic       clk = 1'b0, reset = 1'b1, send = 1'b0;
    logic [3:0] score_a = '0, score_b = '0;
    logic       busy, done, RsTx;

    int         vectors = 0, miscompares = 0;
    logic [7:0] exp_q[$];
    int         sk[$];
    logic [3:0] sa[$], sb[$];
    int         done_at[$];
    int         nbusy, nlow;

    uart_score_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset   (reset),
        .send    (send),
        .score_a (score_a),
        .score_b (score_b),
        .busy    (busy),
        .done    (done),
        .RsTx    (RsTx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic string dig(input int v);
        if (v < 10) return $sformatf("%0d", v);
        return "?";
    endfunction

    function automatic void push_report(input int a, input int b);
        string s;
        s = $sformatf("A:%s B:%s\r\n", dig(a), dig(b));
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endfunction

    task automatic sched(input int k, input logic [3:0] a, input logic [3:0] b);
        sk.push_back(k);
        sa.push_back(a);
        sb.push_back(b);
    endtask

    // negedge k samples cycle k, then drives the inputs seen at the posedge ending cycle k
    task automatic watch(input int n);
        nbusy = 0;
        nlow  = 0;
        done_at.delete();
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                nbusy += int'(busy);
                nlow  += int'(RsTx === 1'b0);
                if (done === 1'b1) done_at.push_back(k);
            end
            if (sk.size() > 0 && sk[0] == k) begin
                send    = 1'b1;
                score_a = sa.pop_front();
                score_b = sb.pop_front();
                void'(sk.pop_front());
            end else begin
                send    = 1'b0;
                score_a = 4'($urandom);
                score_b = 4'($urandom);
            end
        end
        send = 1'b0;
    endtask

    function automatic int done_n(input int i);
        return (done_at.size() > i) ? done_at[i] : -1;
    endfunction

    task automatic single_report(input logic [3:0] a, input logic [3:0] b);
        push_report(a, b);
        sched(0, a, b);
        watch(REPORT + 20);
        chk("busy_cycles", nbusy, REPORT);
        chk("done_count", done_at.size(), 1);
        chk("done_cycle", done_n(0), REPORT + 1);
    endtask

    // Frame monitor: sample mid-bit, abandon the frame if reset appears
    initial begin
        logic [FRAME-1:0] f;
        logic [7:0]       e;
        bit               abort;
        forever begin
            @(negedge clk);
            if (!reset && RsTx === 1'b0) begin
                f     = '0;
                abort = 1'b0;
                for (int k = 1; k <= (FRAME - 1) * CPB + 1; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        abort = 1'b1;
                        break;
                    end
                    if (k % CPB == 1) f[k / CPB] = RsTx;
                end
                if (!abort) begin
                    if (exp_q.size() == 0) chk("spurious_frame", int'(f[8:1]), -1);
                    else begin
                        e = exp_q.pop_front();
                        chk("byte", int'(f[8:1]), int'(e));
                        chk("start_bit", int'(f[0]), 0);
                        chk("stop_bit", int'(f[FRAME-1]), 1);
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", int'(f[9]), int'(^e));
`endif
                    end
                end
            end
        end
    end

    initial begin
        int bad;
        logic [3:0] a, b;
        repeat (3) @(negedge clk);
        chk("rst_RsTx", int'(RsTx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            bad += int'(busy !== 1'b0 || done !== 1'b0 || RsTx !== 1'b1);
        end
        chk("idle_50", bad, 0);

        single_report(4'd3, 4'd7);
        single_report(4'd12, 4'd0);
        repeat (5) single_report(4'($urandom), 4'($urandom));

        // two sends while busy: latest scores win, second report chains with no busy gap
        a = 4'($urandom);
        b = 4'($urandom);
        push_report(a, b);
        push_report(2, 5);
        sched(0, a, b);
        sched($urandom_range(150, 10), 4'd1, 4'd1);
        sched($urandom_range(REPORT, 200), 4'd2, 4'd5);
        watch(2 * REPORT + 20);
        chk("pend_busy_cycles", nbusy, 2 * REPORT);
        chk("pend_done_count", done_at.size(), 2);
        chk("pend_done1", done_n(0), REPORT + 1);
        chk("pend_done2", done_n(1), 2 * REPORT + 1);

        // send in the completion cycle: accepted as idle, one-cycle busy gap
        a = 4'($urandom);
        b = 4'($urandom);
        push_report(a, b);
        push_report(b, a);
        sched(0, a, b);
        sched(REPORT + 1, b, a);
        watch(2 * REPORT + 30);
        chk("donecyc_busy_cycles", nbusy, 2 * REPORT);
        chk("donecyc_done1", done_n(0), REPORT + 1);
        chk("donecyc_done2", done_n(1), 2 * REPORT + 2);

        // reset during byte 2 bit d4 with a report pending
        push_report(4, 9);
        sched(0, 4'd4, 4'd9);
        sched(50, 4'd8, 4'd8);
        watch(100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_RsTx", int'(RsTx), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("bytes_before_reset", exp_q.size(), 7);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        watch(2 * REPORT);
        chk("after_abort_busy", nbusy, 0);
        chk("after_abort_done", done_at.size(), 0);
        chk("after_abort_low", nlow, 0);

        single_report(4'd9, 4'd15);
        repeat (20) @(negedge clk);
        chk("all_bytes_seen", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
